rf_read_stage: RTL and testbench
================================

# rf_read_stage

Operand-fetch stage wrapped around the 16x16 register-file bit-cell array. Decodes source and destination register numbers into the one-hot word lines that drive every cell's ReadEnable1/ReadEnable2/WriteEnable. Captures the two resolved bitline buses into a valid/ready output register, and tracks in-flight destination writes in a scoreboard so that no RAW or WAW hazard reaches the execute stage. R0 reads as zero and is never written.

## Interface
- DATA_W, 16, register/bitline width
- NUM_REGS, 16, number of registers (word lines)
- AW, 4, register index width (log2 NUM_REGS)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_src1, in_src2  in  AW  source register indices
- in_dst  in  AW  destination register index
- in_dst_we  in  1  instruction will write in_dst
- rd_en1, rd_en2  out  NUM_REGS  one-hot read word lines to the array (bit 0 never set)
- bitline1, bitline2  in  DATA_W  resolved read buses from the array
- wb_valid  in  1  write-back this cycle
- wb_reg  in  AW  write-back register
- wb_data  in  DATA_W  write-back value
- wr_en  out  NUM_REGS  one-hot write word lines to the array
- wr_data  out  DATA_W  array write data (= wb_data)
- flush  in  1  kill the instruction held in the output register
- out_valid  out  1  operands valid
- out_ready  in  1  execute consumes this cycle
- out_op1, out_op2  out  DATA_W  captured operands
- out_dst  out  AW; out_dst_we  out  1  forwarded destination info

## Operation
- Accept = in_valid & in_ready. in_ready = ~flush & (~out_valid | out_ready) & ~hazard.
- hazard: any non-zero source with its scoreboard bit set and not bypassed, or in_dst_we with in_dst non-zero and pending (WAW). WAW always stalls, even if the same register is written back in the same cycle.
- rd_enN = onehot(in_srcN) when in_valid and in_srcN != 0, else 0. The array read is combinational, so the bitlines are valid in the same cycle.
- Operand capture on accept: 0 if src == 0; bypassed wb_data if bypass applies; otherwise bitlineN.
- wr_en = onehot(wb_reg) when wb_valid and wb_reg != 0, else 0. A write-back to R0 is dropped.
- Scoreboard (NUM_REGS bits, bit 0 tied 0):
  - Set on accept when in_dst_we is high and in_dst != 0.
  - Cleared by wb_valid for wb_reg.
  - A write-back to a non-pending register still writes the array; the scoreboard is unchanged.
- Output register: holds stable while out_valid & ~out_ready. On accept it loads; otherwise out_valid clears on out_ready.
- flush: out_valid -> 0 next cycle. If the flushed entry had out_dst_we set, its scoreboard bit is cleared. A same-cycle write-back clear for a different register still applies. No accept happens in a flush cycle.

## Timing
- Reset values: out_valid 0, out_op1/out_op2 0, out_dst 0, out_dst_we 0, scoreboard all 0. in_ready is 1 on the first cycle after reset if in_valid.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle when there are no hazards.
- rd_en, wr_en, wr_data and in_ready are combinational.
- Write-back with bypass: a dependent instruction issues in the same cycle as its producer's write-back.
- Write-back without bypass: it issues the cycle after, once the bit-cell has captured the value.

## Configuration
- RF_BYPASS_EN defined: when wb_valid, wb_reg == src and src != 0, that source is not a hazard and its operand is taken from wb_data.
- RF_BYPASS_EN undefined: no forwarding path. The hazard holds until the scoreboard bit clears, which costs one extra stall cycle per RAW dependence.

## Structure
- rf_pkg holds DATA_W, NUM_REGS and AW as localparams, plus an operand-bundle typedef (op1, op2, dst, dst_we).
- Sub-module rf_word_decoder (AW -> NUM_REGS one-hot with enable; index 0 suppressed) is instanced three times: read 1, read 2 and write.

## Test plan
- Reset, then issue src1=3, src2=5 with the array holding R3=0x1234, R5=0x00FF -> rd_en1=0x0008, rd_en2=0x0020; next cycle out_op1=0x1234, out_op2=0x00FF, out_valid=1.
- src1=0, src2=0 -> rd_en1=rd_en2=0, operands 0x0000. A write-back to R0 with data 0xFFFF -> wr_en=0, R0 still reads 0.
- Issue dst=R4, then an instruction with src1=R4 -> in_ready=0 until write-back of 0xBEEF to R4.
  - Bypass on: accepted in the write-back cycle with out_op1=0xBEEF.
  - Bypass off: accepted one cycle later with 0xBEEF.
- Hold out_ready=0 for 3 cycles with a valid output -> out_op1, out_op2 and out_dst remain stable and in_ready=0. Releasing out_ready -> next instruction accepted in that cycle.
- Issue dst=R7, then raise flush while it sits in the output register -> out_valid=0 next cycle, scoreboard[7]=0, and an instruction reading R7 issues without stall.
- WAW: issue dst=R2 twice back-to-back -> second stalls until R2 write-back, including the cycle in which that write-back occurs.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and the operand bundle for the register-file read stage.
package rf_pkg;

    localparam int DATA_W   = 32'd16;
    localparam int NUM_REGS = 32'd16;
    localparam int AW       = 32'd4;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [AW-1:0]     dst;
        logic              dst_we;
    } operand_t;

    // R0 is hardwired to zero, so only non-zero indices name real storage.
    function automatic logic reg_live(input logic [AW-1:0] idx);
        return (idx != {AW{1'b0}});
    endfunction

endpackage

// File: rtl/rf_read_stage_if.sv
// Decode, array, write-back and execute-side signals of rf_read_stage.
interface rf_read_stage_if;
    import rf_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [AW-1:0]       in_src1;
    logic [AW-1:0]       in_src2;
    logic [AW-1:0]       in_dst;
    logic                in_dst_we;
    logic [NUM_REGS-1:0] rd_en1;
    logic [NUM_REGS-1:0] rd_en2;
    logic [DATA_W-1:0]   bitline1;
    logic [DATA_W-1:0]   bitline2;
    logic                wb_valid;
    logic [AW-1:0]       wb_reg;
    logic [DATA_W-1:0]   wb_data;
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_op1;
    logic [DATA_W-1:0]   out_op2;
    logic [AW-1:0]       out_dst;
    logic                out_dst_we;

    modport slave (
        input  in_valid, in_src1, in_src2, in_dst, in_dst_we,
        input  bitline1, bitline2, wb_valid, wb_reg, wb_data,
        input  flush, out_ready,
        output in_ready, rd_en1, rd_en2, wr_en, wr_data,
        output out_valid, out_op1, out_op2, out_dst, out_dst_we
    );

    modport master (
        output in_valid, in_src1, in_src2, in_dst, in_dst_we,
        output bitline1, bitline2, wb_valid, wb_reg, wb_data,
        output flush, out_ready,
        input  in_ready, rd_en1, rd_en2, wr_en, wr_data,
        input  out_valid, out_op1, out_op2, out_dst, out_dst_we
    );

endinterface

// File: rtl/rf_word_decoder.sv
// Index to one-hot word-line decoder; index 0 (R0) never raises a line.
module rf_word_decoder
    import rf_pkg::*;
(
    input  logic                en,
    input  logic [AW-1:0]       idx,
    output logic [NUM_REGS-1:0] onehot
);

    // Word-line decode with R0 suppressed.
    always_comb begin
        onehot = {NUM_REGS{1'b0}};
        if (en && reg_live(idx)) begin
            onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
        end else begin
            onehot = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: rtl/rf_read_stage.sv
// Operand-fetch stage: word-line decode, RAW/WAW scoreboard, valid/ready operand register.
// Optional write-back forwarding is enabled by defining RF_BYPASS_EN.
module rf_read_stage
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rf_read_stage_if.slave  bus
);

    logic [NUM_REGS-1:0] sb_q, sb_d;
    operand_t            out_q, out_d;
    logic                out_valid_q, out_valid_d;

    logic [NUM_REGS-1:0] rd_en1_s, rd_en2_s, wr_en_s;
    logic [NUM_REGS-1:0] flush_clr_s, set_s;
    logic                byp1_s, byp2_s, hazard_s, in_ready_s, accept_s;
    logic [DATA_W-1:0]   op1_s, op2_s;

    rf_word_decoder u_dec_rd1 (.en(bus.in_valid), .idx(bus.in_src1), .onehot(rd_en1_s));
    rf_word_decoder u_dec_rd2 (.en(bus.in_valid), .idx(bus.in_src2), .onehot(rd_en2_s));
    rf_word_decoder u_dec_wr  (.en(bus.wb_valid), .idx(bus.wb_reg),  .onehot(wr_en_s));

    // Forwarding match of each source against the write-back in flight.
    always_comb begin
`ifdef RF_BYPASS_EN
        byp1_s = bus.wb_valid && (bus.wb_reg == bus.in_src1) && reg_live(bus.in_src1);
        byp2_s = bus.wb_valid && (bus.wb_reg == bus.in_src2) && reg_live(bus.in_src2);
`else
        byp1_s = 1'b0;
        byp2_s = 1'b0;
`endif
    end

    // Hazard detection, handshake and operand selection.
    always_comb begin
        // WAW is checked against the registered scoreboard only, so it stalls
        // even through the cycle of the matching write-back.
        hazard_s   = (reg_live(bus.in_src1) && sb_q[bus.in_src1] && !byp1_s)
                  || (reg_live(bus.in_src2) && sb_q[bus.in_src2] && !byp2_s)
                  || (bus.in_dst_we && reg_live(bus.in_dst) && sb_q[bus.in_dst]);
        in_ready_s = !bus.flush && (!out_valid_q || bus.out_ready) && !hazard_s;
        accept_s   = bus.in_valid && in_ready_s;
        op1_s      = !reg_live(bus.in_src1) ? {DATA_W{1'b0}} :
                     (byp1_s ? bus.wb_data : bus.bitline1);
        op2_s      = !reg_live(bus.in_src2) ? {DATA_W{1'b0}} :
                     (byp2_s ? bus.wb_data : bus.bitline2);
    end

    // Scoreboard update: clears from write-back and flush, then set on accept.
    always_comb begin
        flush_clr_s = (bus.flush && out_valid_q && out_q.dst_we)
                    ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << out_q.dst) : {NUM_REGS{1'b0}};
        set_s       = (accept_s && bus.in_dst_we)
                    ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << bus.in_dst) : {NUM_REGS{1'b0}};
        sb_d        = ((sb_q & ~wr_en_s & ~flush_clr_s) | set_s)
                    & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
    end

    // Output register next state: flush kills, accept loads, consume drains.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_d       = '{op1: op1_s, op2: op2_s, dst: bus.in_dst, dst_we: bus.in_dst_we};
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= {NUM_REGS{1'b0}};
            out_q       <= '{op1: {DATA_W{1'b0}}, op2: {DATA_W{1'b0}}, dst: {AW{1'b0}}, dst_we: 1'b0};
            out_valid_q <= 1'b0;
        end else begin
            sb_q        <= sb_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.rd_en1     = rd_en1_s;
    assign bus.rd_en2     = rd_en2_s;
    assign bus.wr_en      = wr_en_s;
    assign bus.wr_data    = bus.wb_data;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_op1    = out_q.op1;
    assign bus.out_op2    = out_q.op2;
    assign bus.out_dst    = out_q.dst;
    assign bus.out_dst_we = out_q.dst_we;

endmodule

// File: tb/tb_rf_read_stage.sv
// Self-checking bench for rf_read_stage: table vectors plus hazard/backpressure/flush sequences.
module tb_rf_read_stage;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_read_stage_if bus();
    rf_read_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    operand_t exp_q[$];

    // Behavioural bit-cell array: combinational read, write on clock edge.
    logic [15:0] mem [16];
    logic [15:0] bl1, bl2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= {4{i[3:0]}};
            mem[0]  <= 16'hDEAD;
            mem[3]  <= 16'h1234;
            mem[5]  <= 16'h00FF;
            mem[15] <= 16'hF0F0;
        end else begin
            for (int i = 0; i < 16; i++) if (bus.wr_en[i]) mem[i] <= bus.wr_data;
        end
    end
    always_comb begin
        bl1 = 16'h0000;
        bl2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (bus.rd_en1[i]) bl1 = bl1 | mem[i];
            if (bus.rd_en2[i]) bl2 = bl2 | mem[i];
        end
    end
    assign bus.bitline1 = bl1;
    assign bus.bitline2 = bl2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the output register whenever execute consumes it; flushed entries are dropped.
    task automatic mon();
        operand_t e;
        if (!rst && bus.out_valid) begin
            if (bus.flush) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end else if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_op1", bus.out_op1, e.op1);
                    chk("out_op2", bus.out_op2, e.op2);
                    chk("out_dst", bus.out_dst, e.dst);
                    chk("out_dst_we", bus.out_dst_we, e.dst_we);
                end
            end
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        mon();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    // Present one instruction until accepted; optional write-back at stall cycle wb_at.
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic we, input logic [15:0] e1, input logic [15:0] e2,
                         input int exp_stall, input int wb_at,
                         input logic [3:0] wreg, input logic [15:0] wdata);
        logic accepted;
        accepted      = 1'b0;
        bus.in_src1   = s1;
        bus.in_src2   = s2;
        bus.in_dst    = d;
        bus.in_dst_we = we;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 12 && !accepted; k++) begin
            if (k == wb_at) begin
                bus.wb_valid = 1'b1;
                bus.wb_reg   = wreg;
                bus.wb_data  = wdata;
            end
            cyc_begin();
            if (bus.in_ready) begin
                exp_q.push_back('{op1: e1, op2: e2, dst: d, dst_we: we});
                accepted = 1'b1;
                chk("stall_cycles", k, exp_stall);
            end
            cyc_end();
            bus.wb_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept expected accept src1=%0d dst=%0d", s1, d);
        end
    endtask

    typedef struct {
        logic [3:0]  s1, s2, d;
        logic [15:0] rd1, rd2, op1, op2;
    } vec_t;
    vec_t vecs[6];

    int raw_stall;

    initial begin
        vecs[0] = '{4'd3,  4'd5,  4'd1, 16'h0008, 16'h0020, 16'h1234, 16'h00FF};
        vecs[1] = '{4'd0,  4'd0,  4'd6, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{4'd15, 4'd1,  4'd2, 16'h8000, 16'h0002, 16'hF0F0, 16'h1111};
        vecs[3] = '{4'd6,  4'd6,  4'd9, 16'h0040, 16'h0040, 16'h6666, 16'h6666};
        vecs[4] = '{4'd0,  4'd9,  4'd0, 16'h0000, 16'h0200, 16'h0000, 16'h9999};
        vecs[5] = '{4'd10, 4'd0, 4'd15, 16'h0400, 16'h0000, 16'hAAAA, 16'h0000};
`ifdef RF_BYPASS_EN
        raw_stall = 2;
`else
        raw_stall = 3;
`endif
        bus.in_valid = 1'b0; bus.in_src1 = 4'd0; bus.in_src2 = 4'd0;
        bus.in_dst = 4'd0; bus.in_dst_we = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_reg = 4'd0; bus.wb_data = 16'h0000;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        cyc_begin();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_op1", bus.out_op1, 16'h0000);
        chk("rst_out_op2", bus.out_op2, 16'h0000);
        chk("rst_out_dst", bus.out_dst, 4'd0);
        chk("rst_out_dst_we", bus.out_dst_we, 1'b0);
        chk("rst_rd_en1_idle", bus.rd_en1, 16'h0000);
        cyc_end();

        // Back-to-back table vectors, no hazards: one accept per cycle
        for (int i = 0; i < 6; i++) begin
            bus.in_src1 = vecs[i].s1; bus.in_src2 = vecs[i].s2;
            bus.in_dst = vecs[i].d; bus.in_dst_we = 1'b0; bus.in_valid = 1'b1;
            cyc_begin();
            chk("rd_en1", bus.rd_en1, vecs[i].rd1);
            chk("rd_en2", bus.rd_en2, vecs[i].rd2);
            chk("in_ready", bus.in_ready, 1'b1);
            if (bus.in_ready)
                exp_q.push_back('{op1: vecs[i].op1, op2: vecs[i].op2, dst: vecs[i].d, dst_we: 1'b0});
            cyc_end();
        end
        bus.in_valid = 1'b0;

        // Write-back to R0 is dropped; write-back to a non-pending register lands
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd0; bus.wb_data = 16'hFFFF;
        cyc_begin();
        chk("wr_en_r0", bus.wr_en, 16'h0000);
        chk("wr_data", bus.wr_data, 16'hFFFF);
        cyc_end();
        bus.wb_reg = 4'd3; bus.wb_data = 16'h5A5A;
        cyc_begin();
        chk("wr_en_r3", bus.wr_en, 16'h0008);
        cyc_end();
        bus.wb_valid = 1'b0;
        issue(4'd3, 4'd0, 4'd0, 1'b0, 16'h5A5A, 16'h0000, 0, -1, 4'd0, 16'h0000);
        issue(4'd0, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000, 0, -1, 4'd0, 16'h0000);

        // RAW on R4 resolved by write-back of 0xBEEF
        issue(4'd0, 4'd0, 4'd4, 1'b1, 16'h0000, 16'h0000, 0, -1, 4'd0, 16'h0000);
        issue(4'd4, 4'd5, 4'd0, 1'b0, 16'hBEEF, 16'h00FF, raw_stall, 2, 4'd4, 16'hBEEF);

        // WAW on R2 stalls through the write-back cycle
        issue(4'd0, 4'd0, 4'd2, 1'b1, 16'h0000, 16'h0000, 0, -1, 4'd0, 16'h0000);
        issue(4'd0, 4'd0, 4'd2, 1'b1, 16'h0000, 16'h0000, 3, 2, 4'd2, 16'h1357);
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd2; bus.wb_data = 16'h2468;
        cyc_begin();
        chk("wr_en_r2", bus.wr_en, 16'h0004);
        cyc_end();
        bus.wb_valid = 1'b0;
        idle(1);

        // Backpressure: output holds for 3 cycles, release accepts in the same cycle
        bus.out_ready = 1'b0;
        issue(4'd1, 4'd2, 4'd9, 1'b0, 16'h1111, 16'h2468, 0, -1, 4'd0, 16'h0000);
        bus.in_src1 = 4'd6; bus.in_src2 = 4'd10; bus.in_dst = 4'd0;
        bus.in_dst_we = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_begin();
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_out_valid", bus.out_valid, 1'b1);
            chk("hold_out_op1", bus.out_op1, 16'h1111);
            chk("hold_out_op2", bus.out_op2, 16'h2468);
            chk("hold_out_dst", bus.out_dst, 4'd9);
            cyc_end();
        end
        bus.out_ready = 1'b1;
        cyc_begin();
        chk("release_in_ready", bus.in_ready, 1'b1);
        if (bus.in_ready)
            exp_q.push_back('{op1: 16'h6666, op2: 16'hAAAA, dst: 4'd0, dst_we: 1'b0});
        cyc_end();
        bus.in_valid = 1'b0;

        // Flush of a pending R7 entry, with a same-cycle write-back clearing R11
        issue(4'd0, 4'd0, 4'd11, 1'b1, 16'h0000, 16'h0000, 0, -1, 4'd0, 16'h0000);
        idle(1);
        bus.out_ready = 1'b0;
        issue(4'd0, 4'd0, 4'd7, 1'b1, 16'h0000, 16'h0000, 0, -1, 4'd0, 16'h0000);
        bus.flush = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_reg = 4'd11; bus.wb_data = 16'h0B0B;
        bus.in_src1 = 4'd7; bus.in_src2 = 4'd0; bus.in_dst = 4'd0;
        bus.in_dst_we = 1'b0; bus.in_valid = 1'b1;
        cyc_begin();
        chk("flush_in_ready", bus.in_ready, 1'b0);
        cyc_end();
        bus.flush = 1'b0; bus.wb_valid = 1'b0;
        cyc_begin();
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("post_flush_in_ready", bus.in_ready, 1'b1);
        if (bus.in_ready)
            exp_q.push_back('{op1: 16'h7777, op2: 16'h0000, dst: 4'd0, dst_we: 1'b0});
        cyc_end();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        issue(4'd11, 4'd0, 4'd0, 1'b0, 16'h0B0B, 16'h0000, 0, -1, 4'd0, 16'h0000);

        // Drain remaining expected outputs
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
